cmd_sched: RTL and testbench

CMD_SCHED -- requirements
Module: cmd_sched

---
 rtl/cmd_sched.sv | 151 +++++++++++++++
 tb/tb_cmd_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// Command scheduler: merges UART and button commands into a FIFO and feeds a scoring engine.
// Define CMD_SCHED_RR_EN for round-robin tie arbitration (default: UART always wins ties).
module cmd_sched #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] uart_cmd,
  input  logic       uart_valid,
  input  logic [3:0] btn_cmd,
  input  logic       btn_valid,
  input  logic       eng_ready,
  output logic [3:0] eng_cmd,
  output logic       eng_valid,
  output logic [1:0] mode,
  output logic       ovf_err,
  output logic       ill_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW+1:0] DepthW = (AW+2)'(FIFO_DEPTH);

  localparam logic [3:0] CmdR  = 4'd0;
  localparam logic [3:0] CmdT1 = 4'd1;
  localparam logic [3:0] CmdT2 = 4'd2;
  localparam logic [3:0] CmdG  = 4'd3;
  localparam logic [3:0] CmdS1 = 4'd4;
  localparam logic [3:0] CmdS2 = 4'd5;
  localparam logic [3:0] CmdS3 = 4'd6;
  localparam logic [3:0] CmdP1 = 4'd7;
  localparam logic [3:0] CmdP2 = 4'd8;

  typedef enum logic [1:0] {ModeIdle = 2'b00, ModeSetup = 2'b01, ModePlay = 2'b10} mode_e;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  mode_e         mode_q;
  logic          toss_q, set_q, ovf_q, ill_q;

  logic [3:0]    head;
  logic          not_empty, head_legal, hs, ill_pop, pop;
  logic [AW+1:0] free;
  logic          btn_first;
  logic          first_v, second_v, push0, push1, drop;
  logic [3:0]    first_c, second_c;
  logic [1:0]    npush;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

  always_comb begin
    head_legal = 1'b0;
    case (mode_q)
      ModeIdle:  head_legal = (head == CmdR);
      ModeSetup: head_legal = (head inside {CmdR, CmdT1, CmdT2, CmdS1, CmdS2, CmdS3}) ||
                              ((head == CmdG) && toss_q && set_q);
      ModePlay:  head_legal = (head inside {CmdR, CmdP1, CmdP2});
      default:   head_legal = 1'b0;
    endcase
  end

  assign eng_valid = not_empty & head_legal;
  assign eng_cmd   = eng_valid ? head : 4'd0;
  assign hs        = eng_valid & eng_ready;
  assign ill_pop   = not_empty & ~head_legal;
  assign pop       = hs | ill_pop;
  assign free      = DepthW - {1'b0, count_q} + (AW+2)'(pop);
  assign mode      = mode_q;
  assign ovf_err   = ovf_q;
  assign ill_err   = ill_q;

`ifdef CMD_SCHED_RR_EN
  logic rr_pri_q;  // 1: button wins the next tie

  assign btn_first = rr_pri_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri_q <= 1'b0;
    end else if (uart_valid && btn_valid) begin
      rr_pri_q <= ~rr_pri_q;
    end
  end
`else
  assign btn_first = 1'b0;
`endif

  always_comb begin
    first_v  = 1'b0;
    first_c  = uart_cmd;
    second_v = 1'b0;
    second_c = btn_cmd;
    if (uart_valid && btn_valid) begin
      first_v  = 1'b1;
      second_v = 1'b1;
      first_c  = btn_first ? btn_cmd : uart_cmd;
      second_c = btn_first ? uart_cmd : btn_cmd;
    end else if (uart_valid) begin
      first_v = 1'b1;
      first_c = uart_cmd;
    end else if (btn_valid) begin
      first_v = 1'b1;
      first_c = btn_cmd;
    end
  end

  assign push0 = first_v && (free != '0);
  assign push1 = second_v && (free >= (AW+2)'(2));
  assign drop  = (first_v && !push0) || (second_v && !push1);
  assign npush = {1'b0, push0} + {1'b0, push1};

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= first_c;
    if (push1) mem_q[wr_ptr_q + AW'(1)] <= second_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= ModeIdle;
      toss_q   <= 1'b0;
      set_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(npush);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q - (AW+1)'(pop) + (AW+1)'(npush);
      ovf_q    <= drop;
      ill_q    <= ill_pop;
      if (hs) begin
        case (head)
          CmdR: begin
            mode_q <= ModeSetup;
            toss_q <= 1'b0;
            set_q  <= 1'b0;
          end
          CmdT1, CmdT2:        toss_q <= 1'b1;
          CmdS1, CmdS2, CmdS3: set_q  <= 1'b1;
          CmdG:                mode_q <= ModePlay;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Directed and random bench for cmd_sched, checked against a queue-based reference model.
module tb_cmd_sched;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] uart_cmd = '0, btn_cmd = '0;
  logic       uart_valid = 1'b0, btn_valid = 1'b0, eng_ready = 1'b0;
  logic [3:0] eng_cmd;
  logic       eng_valid, ovf_err, ill_err;
  logic [1:0] mode;

  always #5 clk = ~clk;

  cmd_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_cmd(uart_cmd), .uart_valid(uart_valid),
    .btn_cmd(btn_cmd), .btn_valid(btn_valid),
    .eng_ready(eng_ready), .eng_cmd(eng_cmd), .eng_valid(eng_valid),
    .mode(mode), .ovf_err(ovf_err), .ill_err(ill_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int mq[$];
  int m_mode;
  bit m_toss, m_set, m_pri, m_ovf, m_ill;
  int hs_log[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit legal(int c);
    case (m_mode)
      0: return c == 0;
      1: return (c inside {0, 1, 2, 4, 5, 6}) || (c == 3 && m_toss && m_set);
      2: return c inside {0, 7, 8};
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_toss = 0;
    m_set = 0;
    m_pri = 0;
    m_ovf = 0;
    m_ill = 0;
  endtask

  task automatic accept(int c);
    case (c)
      0: begin m_mode = 1; m_toss = 0; m_set = 0; end
      1, 2: m_toss = 1;
      4, 5, 6: m_set = 1;
      3: m_mode = 2;
      default: ;
    endcase
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model, end at the next negedge.
  task automatic step(bit uv, int uc, bit bv, int bc, bit rdy);
    bit ev;
    int pop, free;
    int req[$];
    ev = (mq.size() > 0) && legal(mq[0]);
    chk("eng_valid", 32'(eng_valid), 32'(ev));
    chk("eng_cmd", 32'(eng_cmd), ev ? mq[0] : 0);
    chk("mode", 32'(mode), m_mode);
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("ill_err", 32'(ill_err), 32'(m_ill));
    uart_valid = uv; uart_cmd = 4'(uc);
    btn_valid = bv;  btn_cmd = 4'(bc);
    eng_ready = rdy;
    if (eng_valid && rdy) hs_log.push_back(int'(eng_cmd));
    pop = 0;
    m_ill = 0;
    if (mq.size() > 0) begin
      if (!ev) begin
        pop = 1;
        m_ill = 1;
      end else if (rdy) begin
        pop = 1;
        accept(mq[0]);
      end
    end
    free = DEPTH - mq.size() + pop;
    if (uv && bv) begin
      if (m_pri) begin req.push_back(bc); req.push_back(uc); end
      else begin req.push_back(uc); req.push_back(bc); end
`ifdef CMD_SCHED_RR_EN
      m_pri = !m_pri;
`endif
    end else if (uv) req.push_back(uc);
    else if (bv) req.push_back(bc);
    if (pop != 0) void'(mq.pop_front());
    m_ovf = 0;
    foreach (req[i]) begin
      if (free > 0) begin
        mq.push_back(req[i]);
        free--;
      end else m_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
  endtask

  initial begin
    int exp_rr[4];
    model_reset();
    #1;
    chk("rst_valid", 32'(eng_valid), 0);
    chk("rst_cmd", 32'(eng_cmd), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_ill", 32'(ill_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset command enters SETUP
    step(1, 0, 0, 0, 1);
    chk("r_valid", 32'(eng_valid), 1);
    chk("r_cmd", 32'(eng_cmd), 0);
    step(0, 0, 0, 0, 1);
    chk("r_mode", 32'(mode), 1);

    // Toss, set count, go
    step(1, 1, 0, 0, 1);
    step(1, 5, 0, 0, 1);
    step(1, 3, 0, 0, 1);
    idle(2, 1);
    chk("play_mode", 32'(mode), 2);
    step(1, 7, 0, 0, 0);
    chk("p1_cmd", 32'(eng_cmd), 7);
    idle(2, 1);

    // G before toss is illegal
    step(1, 0, 0, 0, 1);
    idle(1, 1);
    step(0, 0, 1, 3, 1);
    chk("g_early_valid", 32'(eng_valid), 0);
    idle(1, 1);
    chk("g_early_ill", 32'(ill_err), 1);
    chk("g_early_mode", 32'(mode), 1);
    idle(1, 1);
    chk("g_early_ill_once", 32'(ill_err), 0);

    // Overflow on the fifth push
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    step(1, 4, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 6, 0, 0, 0);
    chk("ovf_pulse", 32'(ovf_err), 1);
    hs_log.delete();
    idle(6, 1);
    chk("ovf_drain_n", hs_log.size(), 4);
    if (hs_log.size() == 4) begin
      chk("ovf_ord0", hs_log[0], 1);
      chk("ovf_ord1", hs_log[1], 2);
      chk("ovf_ord2", hs_log[2], 4);
      chk("ovf_ord3", hs_log[3], 5);
    end

    // Simultaneous requests in PLAY
    step(1, 3, 0, 0, 1);
    idle(2, 1);
    chk("play2_mode", 32'(mode), 2);
    step(1, 7, 1, 8, 0);
    step(1, 7, 1, 8, 0);
    hs_log.delete();
    idle(6, 1);
`ifdef CMD_SCHED_RR_EN
    exp_rr = '{7, 8, 8, 7};
`else
    exp_rr = '{7, 8, 7, 8};
`endif
    chk("arb_n", hs_log.size(), 4);
    if (hs_log.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("arb_ord%0d", i), hs_log[i], exp_rr[i]);

    // Reset while a command waits on the engine
    step(1, 0, 0, 0, 0);
    idle(1, 0);
    chk("mid_valid", 32'(eng_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(eng_valid), 0);
    chk("mid_rst_cmd", 32'(eng_cmd), 0);
    chk("mid_rst_mode", 32'(mode), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);
    chk("post_rst_valid", 32'(eng_valid), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit uv, bv, rdy;
      int uc, bc;
      uv  = ($urandom_range(0, 99) < 35);
      bv  = ($urandom_range(0, 99) < 25);
      uc  = $urandom_range(0, 10);
      bc  = $urandom_range(0, 10);
      rdy = ($urandom_range(0, 99) < 60);
      step(uv, uc, bv, bc, rdy);
    end
    idle(8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
